matrix_opposite_sequencer: RTL and testbench

Sequential controller that runs the matrix-opposite (element-wise negation) operation of the arithmetic coprocessor against byte-wide matrix memory. On a start command it reads an N×N signed 8-bit matrix (N = 1..5) from memory into a 5×5 operand buffer, applies negation to all 25 elements in one cycle, and writes the N×N result back to a destination address. It sits between the coprocessor instruction decoder and the shared matrix memory port, and owns that port for the whole operation.

---
 rtl/matrix_opposite_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_matrix_opposite_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_opposite_sequencer.sv
// Matrix-opposite sequencer: loads an NxN signed byte matrix, negates all 25 buffer
// elements in one cycle, stores the NxN result back. OPPOSITE_SAT_EN selects saturating negation.
`timescale 1ns/1ps
module matrix_opposite_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [2:0]        i_size,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  output logic              o_mem_rd_en,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wr_data,
  input  logic [7:0]        i_mem_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_ovf,
  output logic [199:0]      o_result_flat
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DRAIN   = 3'd2,
    S_COMPUTE = 3'd3,
    S_STORE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [2:0]        r_size;
  logic [4:0]        r_n;
  logic [4:0]        r_k;
  logic [2:0]        r_row;
  logic [2:0]        r_col;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic              r_err;
  logic              r_cap_vld;
  logic [4:0]        r_cap_pos;
  logic [199:0]      r_buf;
  logic [199:0]      r_result_flat;

  logic              w_size_ok;
  logic              w_accept;
  logic              w_last;
  logic [4:0]        w_pos;
  logic [4:0]        w_n_new;
  logic [ADDR_W-1:0] w_k_ext;
  logic [199:0]      w_neg_flat;

  assign w_size_ok = (i_size != 3'd0) && (i_size <= 3'd5);
  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_last    = (r_k == (r_n - 5'd1));
  // Position of the current element inside the fixed 5x5 buffer.
  assign w_pos     = ({2'b00, r_row} * 5'd5) + {2'b00, r_col};
  assign w_n_new   = {2'b00, i_size} * {2'b00, i_size};
  assign w_k_ext   = ADDR_W'(r_k);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_state_next = w_size_ok ? S_LOAD : S_DONE;
      S_LOAD:    if (w_last) w_state_next = S_DRAIN;
      S_DRAIN:   w_state_next = S_COMPUTE;
      S_COMPUTE: w_state_next = S_STORE;
      S_STORE:   if (w_last) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_mem_rd_en   = 1'b0;
    o_mem_wr_en   = 1'b0;
    o_mem_addr    = '0;
    o_mem_wr_data = 8'h00;
    case (r_state)
      S_LOAD: begin
        o_mem_rd_en = 1'b1;
        o_mem_addr  = r_src + w_k_ext;
      end
      S_STORE: begin
        o_mem_wr_en   = 1'b1;
        o_mem_addr    = r_dst + w_k_ext;
        o_mem_wr_data = r_result_flat[{w_pos, 3'b000} +: 8];
      end
      default: ;
    endcase
    o_busy = (r_state != S_IDLE);
    o_done = (r_state == S_DONE);
    o_err  = (r_state == S_DONE) && r_err;
  end

  // Command latch and element walk (k, row, col) shared by LOAD and STORE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_size    <= 3'd0;
      r_n       <= 5'd0;
      r_k       <= 5'd0;
      r_row     <= 3'd0;
      r_col     <= 3'd0;
      r_src     <= '0;
      r_dst     <= '0;
      r_err     <= 1'b0;
      r_cap_vld <= 1'b0;
      r_cap_pos <= 5'd0;
    end else begin
      // Read data lags the request by one cycle; remember where it belongs.
      r_cap_vld <= (r_state == S_LOAD);
      r_cap_pos <= w_pos;
      if (w_accept) begin
        r_err <= !w_size_ok;
        r_k   <= 5'd0;
        r_row <= 3'd0;
        r_col <= 3'd0;
        if (w_size_ok) begin
          r_size <= i_size;
          r_n    <= w_n_new;
          r_src  <= i_src_addr;
          r_dst  <= i_dst_addr;
        end
      end else if ((r_state == S_LOAD) || (r_state == S_STORE)) begin
        if (w_last) begin
          r_k   <= 5'd0;
          r_row <= 3'd0;
          r_col <= 3'd0;
        end else begin
          r_k <= r_k + 5'd1;
          if (r_col == (r_size - 3'd1)) begin
            r_col <= 3'd0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end
      end
    end
  end

  // Operand buffer: cleared on a legal command so unused entries stay zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf <= '0;
    end else if (w_accept && w_size_ok) begin
      r_buf <= '0;
    end else if (r_cap_vld) begin
      r_buf[{r_cap_pos, 3'b000} +: 8] <= i_mem_rd_data;
    end
  end

`ifdef OPPOSITE_SAT_EN
  logic [24:0] w_is_min;
  logic        r_ovf;
`endif

  generate
    for (genvar gi = 0; gi < 25; gi++) begin : g_neg
`ifdef OPPOSITE_SAT_EN
      assign w_is_min[gi] = (r_buf[gi*8 +: 8] == 8'h80);
      assign w_neg_flat[gi*8 +: 8] = w_is_min[gi] ? 8'h7F : (~r_buf[gi*8 +: 8] + 8'd1);
`else
      assign w_neg_flat[gi*8 +: 8] = ~r_buf[gi*8 +: 8] + 8'd1;
`endif
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result_flat <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_result_flat <= w_neg_flat;
    end
  end

  assign o_result_flat = r_result_flat;

`ifdef OPPOSITE_SAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_COMPUTE) begin
      r_ovf <= |w_is_min;
    end
  end
  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_opposite_sequencer.sv
// Directed bench for matrix_opposite_sequencer: vector table plus reset, start-during-LOAD
// and held-start sequences, checked against a byte-wide memory model.
`timescale 1ns/1ps
module tb_matrix_opposite_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   size;
  logic [7:0]   src_addr;
  logic [7:0]   dst_addr;
  logic         mem_rd_en;
  logic         mem_wr_en;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_wr_data;
  logic [7:0]   mem_rd_data = 8'h00;
  logic         busy;
  logic         done;
  logic         err;
  logic         ovf;
  logic [199:0] result_flat;

  always #5 clk = ~clk;

  matrix_opposite_sequencer #(.ADDR_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_size        (size),
    .i_src_addr    (src_addr),
    .i_dst_addr    (dst_addr),
    .o_mem_rd_en   (mem_rd_en),
    .o_mem_wr_en   (mem_wr_en),
    .o_mem_addr    (mem_addr),
    .o_mem_wr_data (mem_wr_data),
    .i_mem_rd_data (mem_rd_data),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_ovf         (ovf),
    .o_result_flat (result_flat)
  );

  // Byte memory: loaded by the stimulus, read with one cycle of latency.
  logic [7:0] mem [256];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr] : 8'h00;

  typedef struct packed {
    logic [2:0]   size;
    logic [7:0]   src;
    logic [7:0]   dst;
    logic [199:0] din;
    logic [199:0] dexp;
    logic [7:0]   cyc;
    logic         err;
    logic         ovf;
  } vec_t;

  vec_t         vecs [9];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [199:0] exp_flat = '0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Runs one command; poke_cycle > 0 pulses start (size 1) in that cycle.
  task automatic run_cmd(input vec_t v, input int idx, input int poke_cycle);
    int           n;
    int           nn;
    int           rd_cnt;
    int           wr_cnt;
    int           done_cyc;
    logic [199:0] new_flat;
    logic         exp_ovf;
    nn = int'(v.size);
    n  = v.err ? 0 : nn * nn;
    new_flat = '0;
    for (int k = 0; k < n; k++) begin
      new_flat[((k / nn) * 5 + (k % nn)) * 8 +: 8] = v.dexp[k * 8 +: 8];
      mem[8'(v.dst + k)] = 8'hAA;
    end
    for (int k = 0; k < n; k++) mem[8'(v.src + k)] = v.din[k * 8 +: 8];
    if (!v.err) exp_flat = new_flat;
`ifdef OPPOSITE_SAT_EN
    exp_ovf = v.ovf;
`else
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1; size = v.size; src_addr = v.src; dst_addr = v.dst;
    @(posedge clk);
    rd_cnt = 0; wr_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
      @(negedge clk);
      start = (c == poke_cycle);
      if (c == poke_cycle) size = 3'd1;
      chk("busy", busy, 1'b1);
      chk("rd_wr_excl", mem_rd_en & mem_wr_en, 1'b0);
      if (mem_rd_en) begin
        chk("rd_addr", mem_addr, 8'(v.src + rd_cnt));
        rd_cnt++;
      end else if (mem_wr_en) begin
        chk("wr_addr", mem_addr, 8'(v.dst + wr_cnt));
        chk("wr_data", mem_wr_data, v.dexp[wr_cnt * 8 +: 8]);
        wr_cnt++;
      end else begin
        chk("idle_addr", mem_addr, 8'h00);
        chk("idle_wdata", mem_wr_data, 8'h00);
      end
      if (done) begin
        done_cyc = c;
        chk("err", err, v.err);
        chk("ovf", ovf, exp_ovf);
        chk("result_flat", result_flat, exp_flat);
      end
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, v.cyc);
    chk("rd_count", rd_cnt, n);
    chk("wr_count", wr_cnt, n);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_busy", busy, 1'b0);
      chk("post_done", done, 1'b0);
    end
    $display("[TB] cmd %0d size=%0d src=%02h dst=%02h done@%0d reads=%0d writes=%0d",
             idx, v.size, v.src, v.dst, done_cyc, rd_cnt, wr_cnt);
  endtask

  initial begin
    logic [15:0] dmask;
    vecs[0] = '{size: 3'd2, src: 8'h10, dst: 8'h40,
                din: 200'({8'h00, 8'h7F, 8'hFE, 8'h01}),
                dexp: 200'({8'h00, 8'h81, 8'h02, 8'hFF}), cyc: 8'd11, err: 1'b0, ovf: 1'b0};
    vecs[1] = '{size: 3'd5, src: 8'h20, dst: 8'h80, din: {25{8'h80}},
`ifdef OPPOSITE_SAT_EN
                dexp: {25{8'h7F}},
`else
                dexp: {25{8'h80}},
`endif
                cyc: 8'd53, err: 1'b0, ovf: 1'b1};
    vecs[2] = '{size: 3'd0, src: 8'h10, dst: 8'h40, din: '0, dexp: '0, cyc: 8'd1, err: 1'b1, ovf: 1'b0};
    vecs[3] = '{size: 3'd3, src: 8'h30, dst: 8'h50,
                din: 200'({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}),
                dexp: 200'({8'hF7, 8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF}),
                cyc: 8'd21, err: 1'b0, ovf: 1'b0};
    vecs[4] = '{size: 3'd6, src: 8'h10, dst: 8'h40, din: '0, dexp: '0, cyc: 8'd1, err: 1'b1, ovf: 1'b0};
    vecs[5] = '{size: 3'd1, src: 8'h05, dst: 8'h06, din: 200'(8'h7F), dexp: 200'(8'h81),
                cyc: 8'd5, err: 1'b0, ovf: 1'b0};
    vecs[6] = '{size: 3'd2, src: 8'hFE, dst: 8'hFE,
                din: 200'({8'h00, 8'h10, 8'hFF, 8'h05}),
                dexp: 200'({8'h00, 8'hF0, 8'h01, 8'hFB}), cyc: 8'd11, err: 1'b0, ovf: 1'b0};
    vecs[7] = '{size: 3'd4, src: 8'h60, dst: 8'h70, din: 200'({16{8'h01}}),
                dexp: 200'({16{8'hFF}}), cyc: 8'd35, err: 1'b0, ovf: 1'b0};
    vecs[8] = '{size: 3'd7, src: 8'h10, dst: 8'h40, din: '0, dexp: '0, cyc: 8'd1, err: 1'b1, ovf: 1'b0};

    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    rst_n = 1'b0; start = 1'b0; size = 3'd0; src_addr = 8'h00; dst_addr = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wr_data, 8'h00);
    chk("rst_result", result_flat, 200'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], i, 0);

    // Reset asserted during STORE of a 3x3 command.
    @(negedge clk);
    start = 1'b1; size = 3'd3; src_addr = 8'h30; dst_addr = 8'h50;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_rst_in_store", mem_wr_en, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_strobes", {mem_rd_en, mem_wr_en, done, err, ovf}, 5'b00000);
    chk("midrst_addr", mem_addr, 8'h00);
    chk("midrst_wdata", mem_wr_data, 8'h00);
    chk("midrst_result", result_flat, 200'd0);
    $display("[TB] reset applied during STORE");
    @(negedge clk);
    rst_n = 1'b1;
    exp_flat = '0;
    run_cmd(vecs[3], 9, 0);

    // Start pulsed during LOAD must be ignored.
    run_cmd(vecs[0], 10, 2);

    // Start held high: second command accepted on the IDLE cycle after DONE.
    for (int k = 0; k < 1; k++) mem[8'h05] = 8'h7F;
    @(negedge clk);
    start = 1'b1; size = 3'd1; src_addr = 8'h05; dst_addr = 8'h06;
    @(posedge clk);
    dmask = '0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      dmask[c] = done;
      if (c == 6) chk("held_idle_gap", busy, 1'b0);
    end
    start = 1'b0;
    chk("held_done_mask", dmask, 16'h0820);
    @(negedge clk);
    chk("held_post_busy", busy, 1'b0);
    $display("[TB] held start: done mask %04h", dmask);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
